tape_mem: RTL and testbench
===========================

TAPE_MEM -- requirements
Module: tape_mem

Interface
REQ-001 Parameter NCORES, default 4, number of core ports served.
REQ-002 Parameter DEPTH, default 1024, tape words; power of two, 2..65536; AW = log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rd_addr  input  NCORES*16  per-core read pointer (core i at bits [i*16 +: 16]); driven by the core's next-pointer output.
REQ-006 wr_addr  input  NCORES*16  per-core write pointer (core's current pointer).
REQ-007 wr_data  input  NCORES*16  per-core write value.
REQ-008 wr_en  input  NCORES  per-core write strobe.
REQ-009 rd_data  output  NCORES*16  per-core read value; feeds the core's value input.
REQ-010 busy  output  1  high while the tape is being cleared; cores hold off.
REQ-011 wr_conflict  output  1  registered; pulses one cycle after a same-address multi-writer cycle.

Function
REQ-012 Only address bits [AW-1:0] are used; higher bits are ignored, so addresses wrap modulo DEPTH (e.g. DEPTH=1024: 16'h0400 aliases 16'h0000).
REQ-013 FSM states: CLEAR, RUN. CLEAR writes 16'h0000 to word clr_idx each cycle, clr_idx running 0..DEPTH-1; after writing DEPTH-1 the FSM moves to RUN on the next edge.
REQ-014 busy = 1 exactly while in CLEAR (DEPTH cycles after reset deasserts); busy = 0 in RUN.
REQ-015 In CLEAR: wr_en ignored, rd_data all zeros, wr_conflict = 0.
REQ-016 In RUN, reads are combinational: rd_data[i] reflects mem[rd_addr[i]] in the same cycle (zero-cycle latency; cores register it).
REQ-017 In RUN, writes commit on posedge clk; each enabled core writes wr_data[i] to wr_addr[i].
REQ-018 Same-address simultaneous writes: lowest-indexed enabled core wins; others dropped.
REQ-019 wr_conflict asserts for the cycle after any RUN cycle with two or more enabled writers on the same wrapped address; otherwise 0.
REQ-020 Distinct-address writes in the same cycle all commit.
REQ-021 Any number of cores may read any addresses concurrently, including the same address.

Reset
REQ-022 reset forces state CLEAR, clr_idx = 0, wr_conflict = 0 on the next edge; busy = 1 from that edge.
REQ-023 reset asserted mid-CLEAR restarts clearing at word 0; asserted mid-RUN discards any same-cycle writes.
REQ-024 After reset completes, every tape word reads 16'h0000.

Configuration
REQ-025 Macro TAPE_MEM_FWD_EN selects same-cycle write-to-read forwarding.
REQ-026 With TAPE_MEM_FWD_EN defined: if the wrapped rd_addr[i] matches an enabled write address in the same RUN cycle, rd_data[i] = the winning writer's wr_data (per REQ-018), not the stored word.
REQ-027 Without TAPE_MEM_FWD_EN: rd_data[i] always returns the stored word (pre-write value); the new value is visible from the next cycle.

Verification
REQ-028 Reset, then hold reset low 1024 cycles -> busy high for exactly 1024 cycles; then rd_addr = 0, 511, 1023 all read 16'h0000.
REQ-029 RUN: core0 writes 16'h0005 to 16'd128, next cycle core1 reads 16'd128 -> rd_data[1] = 16'h0005; core1 reads 16'h0480 -> 16'h0005 (wrap).
REQ-030 Core0 and core2 both write 16'd200 with 16'h00AA and 16'h00BB -> next cycle mem[200] = 16'h00AA, wr_conflict = 1 for one cycle.
REQ-031 With TAPE_MEM_FWD_EN: core0 writes 16'h0007 to 16'd130 while reading 16'd130 -> rd_data[0] = 16'h0007 same cycle; without macro -> old value 16'h0000.
REQ-032 Assert reset at clear index 300 -> busy stays high a further 1024 cycles from reset release; writes during CLEAR leave the tape all zeros.

Source files
------------

// File: rtl/tape_mem_if.sv
// tape_mem_if: bundle of per-core tape access signals between the cores and tape_mem.
//   rd_addr/wr_addr/wr_data : NCORES x 16-bit fields, core i at bits [i*16 +: 16]
//   wr_en                   : per-core write strobe
//   rd_data                 : per-core read value (combinational from tape_mem)
//   busy                    : tape is being cleared, cores hold off
//   wr_conflict             : registered pulse after a same-address multi-writer cycle
// master = core side, slave = tape_mem side.
interface tape_mem_if #(
    parameter int unsigned NCORES = 4
);
    logic [NCORES*16-1:0] rd_addr;
    logic [NCORES*16-1:0] wr_addr;
    logic [NCORES*16-1:0] wr_data;
    logic [NCORES-1:0]    wr_en;
    logic [NCORES*16-1:0] rd_data;
    logic                 busy;
    logic                 wr_conflict;

    modport master (
        output rd_addr, wr_addr, wr_data, wr_en,
        input  rd_data, busy, wr_conflict
    );

    modport slave (
        input  rd_addr, wr_addr, wr_data, wr_en,
        output rd_data, busy, wr_conflict
    );
endinterface

// File: rtl/tape_mem.sv
// tape_mem: shared multi-port tape of DEPTH 16-bit words serving NCORES cores.
// After reset the tape is cleared one word per cycle (busy high), then it serves
// combinational reads and posedge writes; on same-address writes the lowest core wins.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : tape_mem_if.slave (rd_addr, wr_addr, wr_data, wr_en, rd_data, busy, wr_conflict)
// Optional macro TAPE_MEM_FWD_EN: same-cycle write-to-read forwarding.
module tape_mem #(
    parameter int unsigned NCORES = 4,
    parameter int unsigned DEPTH  = 1024
) (
    input logic       clk,
    input logic       reset,
    tape_mem_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef TAPE_MEM_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            busy_q, busy_d;
    logic            wr_conflict_q, wr_conflict_d;

    logic [15:0]     mem_q [DEPTH];

    logic [AW-1:0]   wa_c [NCORES];
    logic [AW-1:0]   ra_c [NCORES];
    logic [15:0]     wd_c [NCORES];
    logic [NCORES-1:0] win_c;
    logic            conflict_c;

    // Address bits above AW are intentionally ignored (tape wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rd_addr, bus.wr_addr};

    // Field unpack plus write arbitration: a writer wins unless a lower core hits the same word.
    always_comb begin
        win_c      = '0;
        conflict_c = 1'b0;
        for (int i = 0; i < int'(NCORES); i++) begin
            wa_c[i] = bus.wr_addr[i*16 +: AW];
            ra_c[i] = bus.rd_addr[i*16 +: AW];
            wd_c[i] = bus.wr_data[i*16 +: 16];
        end
        for (int i = 0; i < int'(NCORES); i++) begin
            if (bus.wr_en[i]) begin
                win_c[i] = 1'b1;
                for (int j = 0; j < int'(NCORES); j++) begin
                    if (j < i && bus.wr_en[j] && wa_c[j] == wa_c[i]) begin
                        win_c[i]   = 1'b0;
                        conflict_c = 1'b1;
                    end
                end
            end
        end
    end

    // Next-state logic: CLEAR sweeps every word once, then RUN forever.
    always_comb begin
        state_d       = state_q;
        clr_idx_d     = clr_idx_q;
        wr_conflict_d = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_idx_d = AW'(clr_idx_q + 1'b1);
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d   = RUN;
                    clr_idx_d = '0;
                end
            end
            RUN: begin
                wr_conflict_d = conflict_c;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CLEAR;
            clr_idx_q     <= '0;
            busy_q        <= 1'b1;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_idx_q     <= clr_idx_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Storage: clearing write in CLEAR, arbitrated core writes in RUN, nothing while in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[clr_idx_q] <= '0;
            end else begin
                for (int i = 0; i < int'(NCORES); i++) begin
                    if (win_c[i]) begin
                        mem_q[wa_c[i]] <= wd_c[i];
                    end
                end
            end
        end
    end

    // Combinational reads; zeros while clearing. Forwarding picks the (unique) winning writer.
    always_comb begin
        bus.rd_data = '0;
        if (state_q == RUN) begin
            for (int i = 0; i < int'(NCORES); i++) begin
                bus.rd_data[i*16 +: 16] = mem_q[ra_c[i]];
                if (FWD_EN) begin
                    for (int j = 0; j < int'(NCORES); j++) begin
                        if (win_c[j] && wa_c[j] == ra_c[i]) begin
                            bus.rd_data[i*16 +: 16] = wd_c[j];
                        end
                    end
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_tape_mem.sv
// tb_tape_mem: directed + randomized self-checking bench for tape_mem (NCORES=4, DEPTH=1024).
module tb_tape_mem;
    localparam int unsigned NC    = 4;
    localparam int unsigned DEPTH = 1024;

`ifdef TAPE_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tape_mem_if #(.NCORES(NC)) bus ();

    tape_mem #(.NCORES(NC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0]   model [DEPTH];
    logic [15:0]   ra [NC];
    logic [15:0]   wa [NC];
    logic [15:0]   wd [NC];
    logic [NC-1:0] we;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < int'(NC); i++) begin
            bus.rd_addr[i*16 +: 16] = ra[i];
            bus.wr_addr[i*16 +: 16] = wa[i];
            bus.wr_data[i*16 +: 16] = wd[i];
        end
        bus.wr_en = we;
    endtask

    task automatic idle();
        we = '0;
        for (int i = 0; i < int'(NC); i++) begin
            ra[i] = '0;
            wa[i] = '0;
            wd[i] = '0;
        end
        drive();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int k = 0; k < int'(DEPTH); k++) model[k] = '0;
    endtask

    // Expected read: stored word, or (forwarding) data of the lowest enabled writer at that word.
    function automatic logic [15:0] exp_rd(input int i);
        int a;
        a = int'(ra[i]) % int'(DEPTH);
        if (FWD) begin
            for (int j = 0; j < int'(NC); j++)
                if (we[j] && (int'(wa[j]) % int'(DEPTH)) == a) return wd[j];
        end
        return model[a];
    endfunction

    function automatic logic exp_conf();
        for (int i = 0; i < int'(NC); i++)
            for (int j = i + 1; j < int'(NC); j++)
                if (we[i] && we[j] && (int'(wa[i]) % int'(DEPTH)) == (int'(wa[j]) % int'(DEPTH)))
                    return 1'b1;
        return 1'b0;
    endfunction

    // Lowest enabled core wins: apply highest first so lower cores overwrite.
    task automatic commit();
        for (int j = int'(NC) - 1; j >= 0; j--)
            if (we[j]) model[int'(wa[j]) % int'(DEPTH)] = wd[j];
    endtask

    task automatic run_cycle(input string tag);
        logic c;
        drive();
        #1;
        for (int i = 0; i < int'(NC); i++)
            chk($sformatf("%s_rd%0d", tag, i), 64'(bus.rd_data[i*16 +: 16]), 64'(exp_rd(i)));
        c = exp_conf();
        tick();
        commit();
        chk({tag, "_conflict"}, 64'(bus.wr_conflict), 64'(c));
    endtask

    // Count busy cycles after reset release while hammering the write ports.
    task automatic clear_phase(input string tag);
        int cnt;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 2000) begin
            we = NC'($urandom);
            for (int i = 0; i < int'(NC); i++) begin
                wa[i] = 16'($urandom_range(0, 3));
                wd[i] = 16'($urandom) | 16'h0001;
                ra[i] = 16'($urandom);
            end
            drive();
            #1;
            if (cnt % 128 == 0) begin
                chk({tag, "_rd_zero"}, 64'(bus.rd_data), 64'h0);
                chk({tag, "_conf_zero"}, 64'(bus.wr_conflict), 64'h0);
            end
            tick();
            cnt++;
        end
        chk({tag, "_busy_len"}, 64'(cnt), 64'd1024);
        idle();
        model_zero();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        chk("reset_busy", 64'(bus.busy), 64'h1);
        chk("reset_conflict", 64'(bus.wr_conflict), 64'h0);
        chk("reset_rd", 64'(bus.rd_data), 64'h0);

        reset = 1'b0;
        clear_phase("clear1");

        // Reads of cleared words, including a wrapped alias
        ra[0] = 16'd0; ra[1] = 16'd511; ra[2] = 16'd1023; ra[3] = 16'h0405;
        run_cycle("post_clear");
        chk("post_clear_busy", 64'(bus.busy), 64'h0);

        // Write then read back, direct and via wrap
        idle();
        we[0] = 1'b1; wa[0] = 16'd128; wd[0] = 16'h0005;
        run_cycle("w128");
        idle();
        ra[1] = 16'd128; ra[2] = 16'h0480;
        drive();
        #1;
        chk("r128_core1", 64'(bus.rd_data[31:16]), 64'h0005);
        chk("r128_wrap", 64'(bus.rd_data[47:32]), 64'h0005);
        run_cycle("r128");

        // Same-address write: core0 wins, conflict pulses once
        idle();
        we[0] = 1'b1; wa[0] = 16'd200; wd[0] = 16'h00AA;
        we[2] = 1'b1; wa[2] = 16'd200; wd[2] = 16'h00BB;
        ra[3] = 16'd200;
        run_cycle("conf200");
        chk("conf200_pulse", 64'(bus.wr_conflict), 64'h1);
        idle();
        ra[1] = 16'd200;
        drive();
        #1;
        chk("conf200_winner", 64'(bus.rd_data[31:16]), 64'h00AA);
        run_cycle("conf200_after");
        chk("conf200_drop", 64'(bus.wr_conflict), 64'h0);

        // Same-cycle write/read of one word
        idle();
        we[0] = 1'b1; wa[0] = 16'd130; wd[0] = 16'h0007; ra[0] = 16'd130;
        drive();
        #1;
        chk("fwd130", 64'(bus.rd_data[15:0]), FWD ? 64'h0007 : 64'h0000);
        run_cycle("fwd130_cyc");
        idle();
        ra[0] = 16'd130;
        run_cycle("fwd130_next");

        // Randomized traffic on a small wrapped address pool
        for (int n = 0; n < 400; n++) begin
            we = NC'($urandom);
            for (int i = 0; i < int'(NC); i++) begin
                wa[i] = 16'($urandom_range(0, 15)) + 16'(16'h0400 * $urandom_range(0, 63));
                ra[i] = 16'($urandom_range(0, 15)) + 16'(16'h0400 * $urandom_range(0, 63));
                wd[i] = 16'($urandom);
            end
            run_cycle($sformatf("rnd%0d", n));
        end

        // Reset mid-RUN with writes pending, then reset again at clear index 300
        we = '1;
        for (int i = 0; i < int'(NC); i++) begin
            wa[i] = 16'(i * 7 + 1);
            wd[i] = 16'h1234;
        end
        drive();
        reset = 1'b1;
        tick();
        chk("rst_run_busy", 64'(bus.busy), 64'h1);
        reset = 1'b0;
        for (int n = 0; n < 300; n++) begin
            we = '1;
            drive();
            tick();
        end
        chk("mid_clear_busy", 64'(bus.busy), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_phase("clear2");

        // Whole tape must read zero
        for (int k = 0; k < int'(DEPTH) / int'(NC); k++) begin
            idle();
            for (int i = 0; i < int'(NC); i++)
                ra[i] = 16'(k * int'(NC) + i) + 16'(16'h0400 * $urandom_range(0, 63));
            drive();
            #1;
            chk($sformatf("sweep%0d", k), 64'(bus.rd_data), 64'h0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
